scan_test_controller: RTL
=========================

SCAN_TEST_CONTROLLER -- requirements
Module: scan_test_controller

Interface
REQ-001 SHALL declare parameter CHAIN_LEN, default 8, meaning number of flops in the controlled scan chain.
REQ-002 SHALL declare port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL declare port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL declare port start  input  1  request one load/capture/unload test sequence.
REQ-005 SHALL declare port abort  input  1  terminate the current sequence.
REQ-006 SHALL declare port pattern  input  CHAIN_LEN  test vector to shift into the chain.
REQ-007 SHALL declare port expected  input  CHAIN_LEN  golden response for compare.
REQ-008 SHALL declare port scan_out  input  1  serial output of the chain's last flop.
REQ-009 SHALL declare port scan_in  output  1  serial data to the chain.
REQ-010 SHALL declare port scan_en  output  1  chain mode: 1 = shift, 0 = functional capture.
REQ-011 SHALL declare port busy  output  1  high from LOAD through UNLOAD.
REQ-012 SHALL declare port done  output  1  one-cycle pulse ending a completed sequence.
REQ-013 SHALL declare port captured  output  CHAIN_LEN  unloaded chain contents.
REQ-014 SHALL declare port pass  output  1  1 when captured == expected.

Function
REQ-015 SHALL implement states IDLE, LOAD, CAPTURE, UNLOAD, DONE.
REQ-016 IDLE: scan_en=0, scan_in=0, busy=0; start=1 at a rising edge -> LOAD.
REQ-017 LOAD: exactly CHAIN_LEN cycles, scan_en=1, busy=1; cycle k (k=0..CHAIN_LEN-1) drives scan_in=pattern[CHAIN_LEN-1-k] (MSB first); then -> CAPTURE.
REQ-018 CAPTURE: exactly 1 cycle, scan_en=0, scan_in=0, busy=1; then -> UNLOAD.
REQ-019 UNLOAD: exactly CHAIN_LEN cycles, scan_en=1, scan_in=0, busy=1; at the rising edge ending cycle k, scan_out is sampled into captured[CHAIN_LEN-1-k]; then -> DONE.
REQ-020 DONE: exactly 1 cycle, done=1, busy=0, scan_en=0; pass=(captured==expected) valid; then -> IDLE.
REQ-021 Latency: start accepted at edge 0 -> done high during cycle 2*CHAIN_LEN+2 (cycle 18 for CHAIN_LEN=8).
REQ-022 scan_in and scan_en SHALL be stable for the whole cycle (glitch-free, state/counter decoded).
REQ-023 start SHALL be ignored while busy=1 or in DONE; start in IDLE on the cycle after DONE is accepted.
REQ-024 abort=1 in LOAD/CAPTURE/UNLOAD -> IDLE at next edge; no done pulse; captured and pass keep prior values.
REQ-025 abort and start both high in IDLE -> abort wins; stay IDLE.
REQ-026 captured and pass SHALL hold until the next DONE.
REQ-027 Shift counter width SHALL be $clog2(CHAIN_LEN)+1 bits; terminal count CHAIN_LEN-1 with no wrap-around.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, scan_en=0, scan_in=0, busy=0, done=0, captured=0, pass=0, counter=0.
REQ-029 Reset mid-sequence SHALL abandon it without a done pulse; first start after rst_n rises begins a fresh LOAD.

Structure
REQ-030 scan_ctrl_pkg SHALL hold the state enumeration and default CHAIN_LEN constant.
REQ-031 Bit counter SHALL be sub-module scan_bit_counter (clear, enable, terminal-count flag); controller FSM in top module.

Verification
REQ-032 Bench model: 8-bit shift chain; capture loads a*b with a=chain[7:4], b=chain[3:0].
REQ-033 pattern=8'h35, expected=8'h0F, start pulse -> scan_in serial 0,0,1,1,0,1,0,1; done at cycle 18; captured=8'h0F; pass=1.
REQ-034 pattern=8'hFF, expected=8'h00 -> captured=8'hE1, pass=0.
REQ-035 abort high during UNLOAD cycle 3 -> IDLE next edge, no done, captured/pass unchanged from prior run.
REQ-036 rst_n low during LOAD cycle 4 -> all outputs 0 immediately; new start after release gives correct 8'h35 result.
REQ-037 start held high continuously -> back-to-back sequences, done every 19 cycles, no start accepted while busy.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared constants for the scan test controller: default chain length and FSM state codes.
package scan_ctrl_pkg;

    localparam int unsigned CHAIN_LEN_DEFAULT = 8;

    typedef logic [2:0] state_t;

    localparam state_t StIdle    = 3'd0;
    localparam state_t StLoad    = 3'd1;
    localparam state_t StCapture = 3'd2;
    localparam state_t StUnload  = 3'd3;
    localparam state_t StDone    = 3'd4;

endpackage

// File: rtl/scan_bit_counter.sv
// Shift-bit counter with synchronous clear, enable and a terminal-count flag at CHAIN_LEN-1.
module scan_bit_counter #(
    parameter int unsigned CHAIN_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         en_i,
    output logic [$clog2(CHAIN_LEN):0]   count_o,
    output logic                         tc_o
);

    localparam int unsigned CntW = $clog2(CHAIN_LEN) + 1;

    logic [CntW-1:0] cnt_d, cnt_q;

    assign tc_o    = (cnt_q == CntW'(CHAIN_LEN - 1));
    assign count_o = cnt_q;

    // Saturates at terminal count; the FSM clears it on every state exit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_test_controller.sv
// Scan test sequencer: shifts a pattern in, pulses one capture cycle, shifts the response out
// and compares it against the golden value.
module scan_test_controller
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 scan_out,
    output logic                 scan_in,
    output logic                 scan_en,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] captured,
    output logic                 pass
);

    localparam int unsigned CntW = $clog2(CHAIN_LEN) + 1;

    state_t               state_d, state_q;
    logic [CHAIN_LEN-1:0] shift_d, shift_q;
    logic [CHAIN_LEN-1:0] captured_d, captured_q;
    logic                 pass_d, pass_q;
    logic                 cnt_clear, cnt_en, cnt_tc;
    logic [CntW-1:0]      cnt;
    logic [CHAIN_LEN-1:0] pat_shifted;

    scan_bit_counter #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_bit_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .count_o (cnt),
        .tc_o    (cnt_tc)
    );

    // MSB-first serialisation: bit k of the load phase is the top bit after shifting by k.
    assign pat_shifted = pattern << cnt;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        captured_d = captured_q;
        pass_d     = pass_q;
        cnt_clear  = 1'b1;
        cnt_en     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !abort) state_d = StLoad;
            end
            StLoad: begin
                cnt_en    = 1'b1;
                cnt_clear = abort || cnt_tc;
                if (abort)       state_d = StIdle;
                else if (cnt_tc) state_d = StCapture;
            end
            StCapture: begin
                state_d = abort ? StIdle : StUnload;
            end
            StUnload: begin
                cnt_en    = 1'b1;
                cnt_clear = abort || cnt_tc;
                shift_d   = {shift_q[CHAIN_LEN-2:0], scan_out};
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_tc) begin
                    // Results are published only on a completed unload.
                    state_d    = StDone;
                    captured_d = shift_d;
                    pass_d     = (shift_d == expected);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            captured_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            captured_q <= captured_d;
            pass_q     <= pass_d;
        end
    end

    assign scan_en  = (state_q == StLoad) || (state_q == StUnload);
    assign scan_in  = (state_q == StLoad) && pat_shifted[CHAIN_LEN-1];
    assign busy     = (state_q == StLoad) || (state_q == StCapture) || (state_q == StUnload);
    assign done     = (state_q == StDone);
    assign captured = captured_q;
    assign pass     = pass_q;

endmodule
